// File: rtl/cla_mp_sequencer_pkg.sv
// Shared definitions for the word-serial multi-precision add/subtract sequencer.
// Holds the default widths and the controller state encoding.
package cla_mp_sequencer_pkg;

  localparam int W_DEF        = 32;
  localparam int MAXW_LOG_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cla_mp_sequencer_cla32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// Combinational only; the sequencer registers its sum and carry.
module cla32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic [31:0] g;
  logic [31:0] p;
  logic [7:0]  gg;
  logic [7:0]  gp;
  logic [32:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    assign gp[gi] = &p[4*gi +: 4];
    assign gg[gi] = g[4*gi+3]
                  | (p[4*gi+3] & g[4*gi+2])
                  | (p[4*gi+3] & p[4*gi+2] & g[4*gi+1])
                  | (p[4*gi+3] & p[4*gi+2] & p[4*gi+1] & g[4*gi]);
  end

  // Group carry-out comes from the lookahead terms, not the in-group ripple.
  always_comb begin
    c    = '0;
    c[0] = cin_i;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 3; j++) begin
        c[4*i+j+1] = g[4*i+j] | (p[4*i+j] & c[4*i+j]);
      end
      c[4*i+4] = gg[i] | (gp[i] & c[4*i]);
    end
  end

  assign sum_o  = p ^ c[31:0];
  assign cout_o = c[32];

endmodule

// File: rtl/cla_mp_sequencer.sv
// Word-serial multi-precision add/subtract controller sharing one cla32, LS word first.
// Operand and result sides are valid/ready streams; inter-word carry lives in carry_q.
module cla_mp_sequencer
  import cla_mp_sequencer_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int MAXW_LOG = MAXW_LOG_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_sub,
  input  logic [MAXW_LOG-1:0] nwords,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        a_word,
  input  logic [W-1:0]        b_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [W-1:0]        s_word,
  output logic                s_last,
  output logic                done,
  output logic                carry_out,
  output logic                overflow
);

  state_t              state_q, state_d;
  logic [MAXW_LOG-1:0] cnt_q;
  logic [MAXW_LOG-1:0] nwords_q;
  logic                sub_q;
  logic                carry_q;
  logic                out_valid_q;
  logic                s_last_q;
  logic                carry_out_q;
  logic                overflow_q;
  logic [W-1:0]        s_word_q;

  logic [W-1:0]        b_eff;
  logic [W-1:0]        sum;
  logic                cout;
  logic                accept;
  logic                last_accept;

  assign b_eff = sub_q ? ~b_word : b_word;

  cla32 u_cla (
    .a_i    (a_word),
    .b_i    (b_eff),
    .cin_i  (carry_q),
    .sum_o  (sum),
    .cout_o (cout)
  );

  assign in_ready    = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;
  assign last_accept = accept && ((cnt_q + MAXW_LOG'(1)) == nwords_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (nwords == '0) ? DONE : RUN;
      RUN:     if (last_accept) state_d = DRAIN;
      DRAIN:   if (out_valid_q && out_ready && s_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      nwords_q    <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      s_last_q    <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      s_word_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        sub_q    <= op_sub;
        nwords_q <= nwords;
        cnt_q    <= '0;
        carry_q  <= op_sub;
        s_last_q <= 1'b0;
        if (nwords == '0) begin
          carry_out_q <= 1'b0;
          overflow_q  <= 1'b0;
        end
      end
      // A fresh accept refills the output register even while the old word drains.
      if (accept) begin
        cnt_q       <= cnt_q + MAXW_LOG'(1);
        s_word_q    <= sum;
        carry_q     <= cout;
        out_valid_q <= 1'b1;
        s_last_q    <= last_accept;
        if (last_accept) begin
          carry_out_q <= cout;
          overflow_q  <= (a_word[W-1] == b_eff[W-1]) && (sum[W-1] != a_word[W-1]);
        end
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign s_word    = s_word_q;
  assign s_last    = s_last_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_cla_mp_sequencer.sv
// Directed bench for cla_mp_sequencer: hand-computed multi-word vectors,
// backpressure, zero-length operation, ignored start, and mid-operation reset.
module tb_cla_mp_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_sub;
  logic [3:0]  nwords;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_word;
  logic [31:0] b_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s_word;
  logic        s_last;
  logic        done;
  logic        carry_out;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  logic [31:0] av [16];
  logic [31:0] bv [16];
  logic [31:0] ev [16];

  cla_mp_sequencer #(.W(32), .MAXW_LOG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_sub    (op_sub),
    .nwords    (nwords),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s_word    (s_word),
    .s_last    (s_last),
    .done      (done),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one operation with operands av/bv and expected words ev.
  task automatic run_op(input string name, input bit sub, input int n,
                        input logic exp_c, input logic exp_ov,
                        input int stall_word, input bit poke_start);
    int          idx = 0;
    int          rec = 0;
    int          stall = 0;
    int          cyc = 0;
    bit          fin = 0;
    bit          acc;
    logic [31:0] held = '0;
    logic        got_c = 1'b0;
    logic        got_ov = 1'b0;
    start  = 1'b1;
    op_sub = sub;
    nwords = n[3:0];
    step();
    start = 1'b0;
    chk({name, "_busy_after_start"}, busy, 1);
    while (!fin && cyc < 200) begin
      cyc++;
      start = poke_start && (cyc == 2);
      if (start) begin
        nwords = 4'd0;
        op_sub = ~sub;
      end
      in_valid  = (idx < n);
      a_word    = (idx < n) ? av[idx] : 32'h0;
      b_word    = (idx < n) ? bv[idx] : 32'h0;
      out_ready = 1'b1;
      if (out_valid && rec == stall_word && stall < 3) begin
        out_ready = 1'b0;
        if (stall == 0) held = s_word;
        else chk({name, "_hold_s_word"}, s_word, held);
        stall++;
      end
      #1;
      if (!out_ready) chk({name, "_stall_in_ready"}, in_ready, 0);
      if (done) begin
        fin    = 1;
        got_c  = carry_out;
        got_ov = overflow;
        chk({name, "_done_no_out_valid"}, out_valid, 0);
        if (n == 0) chk({name, "_done_latency"}, cyc, 1);
      end
      if (out_valid && out_ready && rec < 16) begin
        $display("[TB] %s word %0d s_word=%h s_last=%0b", name, rec, s_word, s_last);
        chk({name, "_s_word"}, s_word, ev[rec]);
        chk({name, "_s_last"}, s_last, (rec == n - 1));
        rec++;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk({name, "_done_seen"}, fin, 1);
    chk({name, "_word_count"}, rec, n);
    chk({name, "_carry_out"}, got_c, exp_c);
    chk({name, "_overflow"}, got_ov, exp_ov);
    chk({name, "_done_one_cycle"}, done, 0);
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_carry_held"}, carry_out, exp_c);
    in_valid = 1'b1;
    #1;
    chk({name, "_idle_in_ready"}, in_ready, 0);
    in_valid = 1'b0;
    step();
    $display("[TB] %s done carry_out=%0b overflow=%0b", name, got_c, got_ov);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    op_sub    = 1'b0;
    nwords    = 4'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_word    = '0;
    b_word    = '0;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s_word", s_word, 0);
    chk("rst_s_last", s_last, 0);
    chk("rst_done", done, 0);
    chk("rst_carry_out", carry_out, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1'b0;
    step();

    // 0x1_FFFFFFFF + 1 = 0x2_00000000; start pulse mid-run must be ignored
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'h0000_0001; ev[0] = 32'h0000_0000;
    av[1] = 32'h0000_0001; bv[1] = 32'h0000_0000; ev[1] = 32'h0000_0002;
    run_op("add64", 1'b0, 2, 1'b0, 1'b0, -1, 1'b1);

    // 5 - 7 borrows: 0xFFFFFFFE, no carry
    av[0] = 32'd5; bv[0] = 32'd7; ev[0] = 32'hFFFF_FFFE;
    run_op("sub_borrow", 1'b1, 1, 1'b0, 1'b0, -1, 1'b0);

    // signed overflow on MS word
    av[0] = 32'h7FFF_FFFF; bv[0] = 32'h0000_0001; ev[0] = 32'h8000_0000;
    run_op("add_ovf", 1'b0, 1, 1'b0, 1'b1, -1, 1'b0);

    // 64-bit subtract 0 - 0x1_00000000 = 0xFFFFFFFF_00000000, borrow
    av[0] = 32'h0; bv[0] = 32'h0000_0000; ev[0] = 32'h0000_0000;
    av[1] = 32'h0; bv[1] = 32'h0000_0001; ev[1] = 32'hFFFF_FFFF;
    run_op("sub64", 1'b1, 2, 1'b0, 1'b0, -1, 1'b0);

    // 128-bit add with out_ready low for 3 cycles on the second word
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'h0000_0001; ev[0] = 32'h0000_0000;
    av[1] = 32'h8000_0000; bv[1] = 32'h8000_0000; ev[1] = 32'h0000_0001;
    av[2] = 32'h0000_0010; bv[2] = 32'h0000_0020; ev[2] = 32'h0000_0031;
    av[3] = 32'h7FFF_FFFF; bv[3] = 32'h0000_0000; ev[3] = 32'h7FFF_FFFF;
    run_op("add128_bp", 1'b0, 4, 1'b0, 1'b0, 1, 1'b0);

    // single word with carry out, leaves carry_out=1 for the reset test
    av[0] = 32'hFFFF_FFFF; bv[0] = 32'h0000_0001; ev[0] = 32'h0000_0000;
    run_op("add_carry", 1'b0, 1, 1'b1, 1'b0, -1, 1'b0);

    run_op("zero_len", 1'b1, 0, 1'b0, 1'b0, -1, 1'b0);

    // reset after 2 of 4 words accepted
    start = 1'b1; op_sub = 1'b0; nwords = 4'd4;
    step();
    start = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1; a_word = 32'hFFFF_FFFF; b_word = 32'h1;
    step();
    a_word = 32'h1234_5678; b_word = 32'h0;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("mid_busy_before_rst", busy, 1);
    chk("mid_out_valid_before_rst", out_valid, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_s_word", s_word, 0);
    chk("mid_rst_s_last", s_last, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_carry_out", carry_out, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_rst_no_done", done, 0);
    end
    $display("[TB] mid_rst checked");

    av[0] = 32'h0000_0003; bv[0] = 32'h0000_0004; ev[0] = 32'h0000_0007;
    run_op("after_rst", 1'b0, 1, 1'b0, 1'b0, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
